// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous data memory between the CPU (port 0) and DMA (port 1).
// Latency: ack in cycle k+2+MEM_LAT for a request sampled at the end of cycle k; losers and late arrivals wait with req held.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_cpu_stall,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_grant_vld;
    logic              w_grant;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        w_grant_vld = i_req0 | i_req1;
        w_grant     = (i_req0 && i_req1) ? ~r_last_grant : i_req1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_we         <= w_grant ? i_we1    : i_we0;
                        r_addr       <= w_grant ? i_addr1  : i_addr0;
                        r_wdata      <= w_grant ? i_wdata1 : i_wdata0;
                    end
                end
                S_ISSUE: r_cnt <= 4'(MEM_LAT - 1);
                S_WAIT: begin
                    // Writes capture too, so rdata always reflects the last completed access.
                    if (r_cnt == 4'd0) begin
                        r_rdata <= i_mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_en    = (r_state == S_ISSUE);
        o_mem_we    = (r_state == S_ISSUE) & r_we;
        o_ack0      = (r_state == S_ACK) & ~r_owner;
        o_ack1      = (r_state == S_ACK) &  r_owner;
        o_cpu_stall = i_reset & i_req0 & ~((r_state == S_ACK) & ~r_owner);
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle table for MEM_LAT=2 plus contention, reset-abort and MEM_LAT=1 sequences.
module tb_dmem_arbiter;

    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] BAD = 32'hBAD0BAD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, stall, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        q_req0, q_we0, q_req1, q_we1;
    logic [31:0] q_addr0, q_wdata0, q_addr1, q_wdata1;
    logic        q_ack0, q_ack1, q_stall, q_mem_en, q_mem_we;
    logic [31:0] q_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_ack0(ack0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_ack1(ack1),
        .o_rdata(rdata), .o_cpu_stall(stall), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0(q_req0), .i_we0(q_we0), .i_addr0(q_addr0), .i_wdata0(q_wdata0), .o_ack0(q_ack0),
        .i_req1(q_req1), .i_we1(q_we1), .i_addr1(q_addr1), .i_wdata1(q_wdata1), .o_ack1(q_ack1),
        .o_rdata(q_rdata), .o_cpu_stall(q_stall), .o_mem_en(q_mem_en), .o_mem_we(q_mem_we),
        .o_mem_addr(q_mem_addr), .o_mem_wdata(q_mem_wdata), .i_mem_rdata(q_mem_rdata)
    );

    function automatic logic [31:0] dflt(input logic [4:0] idx);
        return (idx == 5'd20) ? DB : (32'hA5A50000 | {27'd0, idx});
    endfunction

    // Memory model, 2-cycle latency; read data is poisoned outside the valid cycle.
    logic [31:0] mem0 [32];
    logic        s1v = 1'b0, s2v = 1'b0;
    logic [31:0] s1, s2;
    initial for (int i = 0; i < 32; i++) mem0[i] = dflt(5'(i));
    always @(posedge clk) begin
        s1v <= mem_en;
        if (mem_en) begin
            s1 <= mem0[mem_addr[6:2]];
            if (mem_we) mem0[mem_addr[6:2]] <= mem_wdata;
        end
        s2  <= s1;
        s2v <= s1v;
    end
    assign mem_rdata = s2v ? s2 : BAD;

    // Memory model, 1-cycle latency, read-only.
    logic        q_s1v = 1'b0;
    logic [31:0] q_s1;
    always @(posedge clk) begin
        q_s1v <= q_mem_en;
        q_s1  <= dflt(q_mem_addr[6:2]);
    end
    assign q_mem_rdata = q_s1v ? q_s1 : BAD;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        r0, w0, r1, w1;
        logic [31:0] a0, d0, a1, d1;
        logic        e_ack0, e_ack1, e_en, e_we, e_stall, c_rd;
        logic [31:0] e_addr, e_wd, e_rd;
    } vec_t;

    function automatic vec_t mk(input int r0, input int w0, input logic [31:0] a0, input logic [31:0] d0,
                                input int r1, input int w1, input logic [31:0] a1, input logic [31:0] d1,
                                input int ea0, input int ea1, input int een, input int ewe,
                                input logic [31:0] eaddr, input logic [31:0] ewd,
                                input int est, input int crd, input logic [31:0] erd);
        vec_t v;
        v.r0 = (r0 != 0); v.w0 = (w0 != 0); v.a0 = a0; v.d0 = d0;
        v.r1 = (r1 != 0); v.w1 = (w1 != 0); v.a1 = a1; v.d1 = d1;
        v.e_ack0 = (ea0 != 0); v.e_ack1 = (ea1 != 0); v.e_en = (een != 0); v.e_we = (ewe != 0);
        v.e_addr = eaddr; v.e_wd = ewd; v.e_stall = (est != 0); v.c_rd = (crd != 0); v.e_rd = erd;
        return v;
    endfunction

    vec_t vt [26];

    initial begin
        int nack, nen;
        // CPU write to 84, DMA read of 80, CPU read-back with a late DMA write, CPU read of the DMA write.
        vt[0]  = mk(1,1,84,7,    0,0,0,0,        0,0,0,0,0,0,   1,1,0);
        vt[1]  = mk(1,1,84,7,    0,0,0,0,        0,0,1,1,84,7,  1,1,0);
        vt[2]  = mk(1,1,84,7,    0,0,0,0,        0,0,0,0,0,0,   1,0,0);
        vt[3]  = mk(1,1,84,7,    0,0,0,0,        0,0,0,0,0,0,   1,0,0);
        vt[4]  = mk(1,1,84,7,    0,0,0,0,        1,0,0,0,0,0,   0,1,32'hA5A50015);
        vt[5]  = mk(0,0,0,0,     1,0,80,0,       0,0,0,0,0,0,   0,1,32'hA5A50015);
        vt[6]  = mk(0,0,0,0,     1,0,80,0,       0,0,1,0,80,0,  0,0,0);
        vt[7]  = mk(0,0,0,0,     1,0,80,0,       0,0,0,0,0,0,   0,0,0);
        vt[8]  = mk(0,0,0,0,     1,0,80,0,       0,0,0,0,0,0,   0,0,0);
        vt[9]  = mk(0,0,0,0,     1,0,80,0,       0,1,0,0,0,0,   0,1,DB);
        vt[10] = mk(1,0,84,0,    0,0,0,0,        0,0,0,0,0,0,   1,1,DB);
        vt[11] = mk(1,0,84,0,    0,0,0,0,        0,0,1,0,84,0,  1,0,0);
        vt[12] = mk(1,0,84,0,    1,1,88,32'h1234, 0,0,0,0,0,0,  1,0,0);
        vt[13] = mk(1,0,84,0,    1,1,88,32'h1234, 0,0,0,0,0,0,  1,0,0);
        vt[14] = mk(1,0,84,0,    1,1,88,32'h1234, 1,0,0,0,0,0,  0,1,7);
        vt[15] = mk(0,0,0,0,     1,1,88,32'h1234, 0,0,0,0,0,0,  0,1,7);
        vt[16] = mk(0,0,0,0,     1,1,88,32'h1234, 0,0,1,1,88,32'h1234, 0,0,0);
        vt[17] = mk(0,0,0,0,     1,1,88,32'h1234, 0,0,0,0,0,0,  0,0,0);
        vt[18] = mk(0,0,0,0,     1,1,88,32'h1234, 0,0,0,0,0,0,  0,0,0);
        vt[19] = mk(0,0,0,0,     1,1,88,32'h1234, 0,1,0,0,0,0,  0,1,32'hA5A50016);
        vt[20] = mk(1,0,88,0,    0,0,0,0,        0,0,0,0,0,0,   1,1,32'hA5A50016);
        vt[21] = mk(1,0,88,0,    0,0,0,0,        0,0,1,0,88,0,  1,0,0);
        vt[22] = mk(1,0,88,0,    0,0,0,0,        0,0,0,0,0,0,   1,0,0);
        vt[23] = mk(1,0,88,0,    0,0,0,0,        0,0,0,0,0,0,   1,0,0);
        vt[24] = mk(1,0,88,0,    0,0,0,0,        1,0,0,0,0,0,   0,1,32'h1234);
        vt[25] = mk(0,0,0,0,     0,0,0,0,        0,0,0,0,0,0,   0,1,32'h1234);

        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 84; wdata0 = 7;
        req1 = 1'b0; we1 = 1'b0; addr1 = 0;  wdata1 = 0;
        q_req0 = 1'b0; q_we0 = 1'b0; q_addr0 = 0; q_wdata0 = 0;
        q_req1 = 1'b0; q_we1 = 1'b0; q_addr1 = 0; q_wdata1 = 0;
        #12;
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        chk32("rst_rdata", rdata, 32'd0);
        chk1("rst_stall", stall, 1'b0);

        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
            req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
            #3;
            chk1($sformatf("v%0d_ack0", i), ack0, vt[i].e_ack0);
            chk1($sformatf("v%0d_ack1", i), ack1, vt[i].e_ack1);
            chk1($sformatf("v%0d_mem_en", i), mem_en, vt[i].e_en);
            chk1($sformatf("v%0d_mem_we", i), mem_we, vt[i].e_we);
            chk1($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
            if (vt[i].e_en) begin
                chk32($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_addr);
                chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_wd);
            end
            if (vt[i].c_rd) chk32($sformatf("v%0d_rdata", i), rdata, vt[i].e_rd);
        end

        // Contention from reset release: grants alternate 0,1,0,1 every MEM_LAT+3 cycles.
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        #1 chk1("cont_rst_stall", stall, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        nack = 0; nen = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            #3;
            if (mem_en) begin
                chk32("cont_en_cycle", 32'(c), 32'(1 + 5 * nen));
                chk32("cont_mem_addr", mem_addr, (nen % 2 == 1) ? 32'h20 : 32'h10);
                nen++;
            end
            if (ack0 || ack1) begin
                chk32("cont_ack_cycle", 32'(c), 32'(4 + 5 * nack));
                chk1("cont_ack1_owner", ack1, (nack % 2) == 1);
                chk1("cont_ack0_owner", ack0, (nack % 2) == 0);
                nack++;
            end
        end
        chk32("cont_ack_count", 32'(nack), 32'd4);

        // Reset during WAIT drops the transaction; a fresh request afterwards completes.
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 80;
        @(posedge clk); #3 chk1("ra_issue_en", mem_en, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk1("ra_mem_en", mem_en, 1'b0);
        chk1("ra_ack0", ack0, 1'b0);
        chk1("ra_stall", stall, 1'b0);
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #3 chk1("ra_hold_ack0", ack0, 1'b0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #3;
            chk1("ra_post_ack0", ack0, 1'b0);
            chk1("ra_post_en", mem_en, 1'b0);
        end
        @(posedge clk); #1 req0 = 1'b1; we0 = 1'b0; addr0 = 80;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #3;
            chk1($sformatf("ra_fresh_ack0_c%0d", c), ack0, c == 4);
            if (c == 1) chk1("ra_fresh_en", mem_en, 1'b1);
            if (c == 4) chk32("ra_fresh_rdata", rdata, DB);
        end
        @(posedge clk); #1 req0 = 1'b0;

        // MEM_LAT=1 instance: ack three cycles after the request edge.
        q_req0 = 1'b1; q_we0 = 1'b0; q_addr0 = 80;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #3;
            chk1($sformatf("l1_ack0_c%0d", c), q_ack0, c == 3);
            chk1($sformatf("l1_en_c%0d", c), q_mem_en, c == 1);
            if (c == 3) chk32("l1_rdata", q_rdata, DB);
        end
        @(posedge clk); #1 q_req0 = 1'b0;
        #3 chk1("l1_ack_after", q_ack0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipelined CPU's MEM stage (port 0) and a DMA/test-loader port (port 1).
- Arbitrates between them with round-robin priority.
- Sequences each access against a fixed-latency synchronous memory.
- Returns read data and a one-cycle ack to the owner. Holding `cpu_stall` while port 0 waits freezes the pipeline.
- Sits between the processor core and dmem inside top.

Parameters:
- `ADDR_W`, 32: address width, byte address.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from the `mem_en` pulse to valid `mem_rdata`. Legal range is 1 to 15.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets, 1 runs.
- `req0`  in  1  port 0 (CPU) request.
- `we0`  in  1  port 0 write enable.
- `addr0`  in  ADDR_W  port 0 address.
- `wdata0`  in  DATA_W  port 0 write data.
- `ack0`  out  1  port 0 transaction complete; one-cycle pulse.
- `req1` / `we1` / `addr1` / `wdata1` / `ack1`: same meaning for port 1 (DMA).
- `rdata`  out  DATA_W  read data, valid only in an ack cycle.
- `cpu_stall`  out  1  high while `req0` is high and `ack0` is low.
- `mem_en`  out  1  memory access strobe; one-cycle pulse.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE and the latency counter to 0.
  - `last_grant` goes to 1, so port 0 wins the first tie.
  - `ack0`, `ack1`, `mem_en`, `mem_we` are 0; `mem_addr`, `mem_wdata`, `rdata` are 0.
  - Any in-flight transaction is dropped and never acked.
- Requester protocol:
  - Assert `req`; hold `we`/`addr`/`wdata` stable until the ack cycle.
  - Drop `req` or issue a new request the cycle after ack.
  - Deasserting `req` before ack is illegal. The arbiter still completes and acks the transaction.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - At the clock edge, if any `req` is high, choose a winner:
    - only one requesting: that one wins;
    - both requesting: the port not equal to `last_grant` wins.
  - Register the winner's `we`/`addr`/`wdata` and owner id, update `last_grant`, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (one cycle):
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` driven from the registered fields.
  - Counter loads `MEM_LAT`-1; go to WAIT.
  - `mem_addr`/`mem_wdata` may hold their value outside ISSUE, but `mem_en`=0 there.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata` into the `rdata` register (all transactions, including writes) and go to ACK.
  - With `MEM_LAT`=1, WAIT lasts exactly one cycle.
- ACK (one cycle): the owner's ack=1, the other ack=0, `rdata` holds the captured value; go to IDLE. No arbitration happens in ACK.
- Latency:
  - `req` sampled in IDLE at the end of cycle k gives `mem_en` in cycle k+1 and ack in cycle k+2+`MEM_LAT`.
  - Minimum period per transaction is `MEM_LAT`+3 cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1,...
- A request arriving while busy waits in place. It is never lost, and its `cpu_stall` stays high.
- `cpu_stall` is combinational: `req0` AND NOT `ack0`. It is 0 during reset.
- `rdata` holds its last captured value between acks.

Test Plan:
- CPU write, `MEM_LAT`=2: `req0`=1, `we0`=1, `addr0`=84, `wdata0`=7 at cycle 0 → `mem_en`=1 with `mem_we`=1, `mem_addr`=84, `mem_wdata`=7 in cycle 1 only; `ack0`=1 in cycle 4; `cpu_stall`=1 in cycles 0-3, 0 in cycle 4.
- Read: memory returns 0xDEADBEEF for `addr1`=80 with `we1`=0 → `ack1` pulses once; `rdata`=0xDEADBEEF in the ack cycle; `ack0` stays 0.
- Contention: both ports request continuously from reset release → grant order 0,1,0,1; acks every 5 cycles; `mem_addr` alternates between `addr0` and `addr1`.
- Late arrival: `req1` rises while port 0 is in WAIT → `req1` is not serviced until after `ack0`; it is granted at the next IDLE edge.
- Reset mid-operation: drop `reset` to 0 during WAIT → `mem_en`, ack and state clear immediately, no ack is ever issued for that transaction; after release a fresh request completes normally.
- `MEM_LAT`=1: single read → ack 3 cycles after the request edge; the captured `mem_rdata` is correct.
